// File: rtl/d_mem_hs.sv
// Byte-addressed, word-organised data RAM with byte strobes and alignment/range error reporting.
// Latency: rsp_valid asserts LATENCY cycles after the request accept edge.
// Backpressure: one outstanding transaction; req_ready stays low until the response handshake.
module d_mem_hs #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);
    localparam int B   = DATA_W / 8;
    localparam int OFS = $clog2(B);
    localparam int IW  = $clog2(DEPTH);
    localparam int CW  = $clog2(LATENCY + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              misaligned;
    logic              out_of_range;
    logic              addr_err;
    logic [IW-1:0]     idx;

    assign req_ready    = (state == IDLE);
    assign rsp_valid    = (state == RESP);
    assign accept       = req_valid && req_ready;
    // Mask is zero for byte-wide words, so the alignment check disappears there.
    assign misaligned   = (req_addr & ADDR_W'(B - 1)) != '0;
    assign out_of_range = (req_addr >> (OFS + IW)) != '0;
    assign addr_err     = misaligned || out_of_range;
    assign idx          = req_addr[OFS+IW-1:OFS];

    // Response payload is gated so nothing leaks out while no response is presented.
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid && err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        err_q   <= addr_err;
                        rdata_q <= (req_we || addr_err) ? '0 : mem[idx];
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CW'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && req_we && !addr_err) begin
            for (int i = 0; i < B; i++) begin
                if (req_be[i]) begin
                    mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_d_mem_hs.sv
// Bench for d_mem_hs: three instances with LATENCY 1, 4 and 3, each with its own reset.
module tb_d_mem_hs;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        d_mem_hs #(
            .DATA_W (32),
            .DEPTH  (256),
            .ADDR_W (32),
            .LATENCY((g == 0) ? 1 : ((g == 1) ? 4 : 3))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_we   (req_we[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .req_be   (req_be[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g])
        );
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Full transaction with rsp_ready high; lat counts cycles from accept edge to rsp_valid.
    task automatic txn(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_be[k]    = be;
        rsp_ready[k] = 1'b1;
        n = 0;
        while (!req_ready[k] && n < 64) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        req_addr[k]  = 32'hFFFF_FFFF;
        req_wdata[k] = 32'h0BAD_0BAD;
        lat = 0;
        while (lat < 64) begin
            @(negedge clk);
            lat++;
            if (rsp_valid[k]) break;
        end
        rd = rsp_rdata[k];
        er = rsp_err[k];
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          bad;
    int          last_acc;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 32'h11BB_33DD, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0022, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b1, 32'h0000_0400, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b0};
        vecs[11] = '{1'b1, 32'h0000_03FC, 32'h0102_0304, 4'hF, 32'h0000_0000, 1'b0};
        vecs[12] = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 4'h0, 32'h0102_0304, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_0401, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
        vecs[14] = '{1'b1, 32'h8000_0000, 32'h5A5A_5A5A, 4'hF, 32'h0000_0000, 1'b1};
        vecs[15] = '{1'b1, 32'h0000_0024, 32'hA5A5_A5A5, 4'hF, 32'h0000_0000, 1'b0};
        vecs[16] = '{1'b1, 32'h0000_0024, 32'h0000_0000, 4'h8, 32'h0000_0000, 1'b0};
        vecs[17] = '{1'b0, 32'h0000_0024, 32'h0000_0000, 4'h0, 32'h00A5_A5A5, 1'b0};
        vecs[18] = '{1'b1, 32'h0000_03FD, 32'hEEEE_EEEE, 4'hF, 32'h0000_0000, 1'b1};
        vecs[19] = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 4'h0, 32'h0102_0304, 1'b0};

        for (int k = 0; k < 3; k++) begin
            rst_n[k]     = 1'b0;
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            req_be[k]    = '0;
            rsp_ready[k] = 1'b1;
        end
        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(req_ready[0]), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("reset rsp_rdata", rsp_rdata[0], 32'd0);
        chk("reset rsp_err", 32'(rsp_err[0]), 32'd0);
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;

        // LATENCY=1 directed table
        for (int i = 0; i < 20; i++) begin
            txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
            chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd1);
        end
        @(negedge clk);
        chk("idle after table rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("idle after table rsp_rdata", rsp_rdata[0], 32'd0);
        chk("idle after table req_ready", 32'(req_ready[0]), 32'd1);

        // LATENCY=4 with response backpressure
        txn(1, 1'b1, 32'h40, 32'h8765_4321, 4'hF, rd, er, lat);
        chk("l4 write latency", 32'(lat), 32'd4);
        chk("l4 write rdata", rd, 32'd0);
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_addr[1]  = 32'h40;
        req_be[1]    = 4'h0;
        rsp_ready[1] = 1'b0;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'h44;
        req_wdata[1] = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("bp c%0d req_ready", c), 32'(req_ready[1]), 32'd0);
            if (c < 4) begin
                chk($sformatf("bp c%0d rsp_valid", c), 32'(rsp_valid[1]), 32'd0);
                chk($sformatf("bp c%0d rsp_rdata", c), rsp_rdata[1], 32'd0);
            end else begin
                chk($sformatf("bp c%0d rsp_valid", c), 32'(rsp_valid[1]), 32'd1);
                chk($sformatf("bp c%0d rsp_rdata", c), rsp_rdata[1], 32'h8765_4321);
                chk($sformatf("bp c%0d rsp_err", c), 32'(rsp_err[1]), 32'd0);
            end
        end
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        chk("bp after hs req_ready", 32'(req_ready[1]), 32'd1);
        chk("bp after hs rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("bp after hs rsp_rdata", rsp_rdata[1], 32'd0);
        req_we[1] = 1'b0;

        // LATENCY=3: reset during WAIT drops the response but keeps the write
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 32'h30;
        req_wdata[2] = 32'h55;
        req_be[2]    = 4'hF;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        @(posedge clk);
        #1;
        chk("wait state req_ready", 32'(req_ready[2]), 32'd0);
        rst_n[2] = 1'b0;
        #1;
        chk("mid reset req_ready", 32'(req_ready[2]), 32'd1);
        chk("mid reset rsp_valid", 32'(rsp_valid[2]), 32'd0);
        chk("mid reset rsp_rdata", rsp_rdata[2], 32'd0);
        chk("mid reset rsp_err", 32'(rsp_err[2]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n[2] = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[2]) bad++;
        end
        chk("no response after reset", 32'(bad), 32'd0);
        txn(2, 1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
        chk("post reset read rdata", rd, 32'h55);
        chk("post reset read latency", 32'(lat), 32'd3);

        // LATENCY=4 back-to-back writes with req_valid held high
        @(negedge clk);
        rsp_ready[1] = 1'b1;
        last_acc = 0;
        for (int i = 0; i < 8; i++) begin
            int n;
            req_valid[1] = 1'b1;
            req_we[1]    = 1'b1;
            req_addr[1]  = 32'h100 + 32'(4 * i);
            req_wdata[1] = 32'hB0B0_0000 + 32'(i);
            req_be[1]    = 4'hF;
            n = 0;
            while (!req_ready[1] && n < 64) begin
                @(negedge clk);
                n++;
            end
            if (i > 0) chk($sformatf("b2b accept spacing %0d", i), 32'(cyc - last_acc), 32'd5);
            last_acc = cyc;
            @(posedge clk);
            #1;
        end
        req_valid[1] = 1'b0;
        req_we[1]    = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            txn(1, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'h0, rd, er, lat);
            chk($sformatf("b2b readback %0d", i), rd, 32'hB0B0_0000 + 32'(i));
        end
        txn(1, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
        chk("l4 reread 0x40", rd, 32'h8765_4321);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
